imem_boot_loader: RTL and testbench

- Upstream program-load stage for the single-cycle MIPS32 core.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port.
- Holds the core in reset until the full program is loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 127 ++++++++++++
 tb/tb_imem_boot_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a 16-bit big-endian word count followed by big-endian instruction
// words from a byte stream, writes them into IMEM, then releases the core from reset.
//   state  | meaning
//   IDLE   | one-cycle settle after reset or reboot
//   LEN_HI | waiting for length byte [15:8]
//   LEN_LO | waiting for length byte [7:0], range check
//   LOAD   | assembling words and pulsing im_we
//   FLUSH  | last write retiring
//   DONE   | program loaded, core running
//   ERR    | illegal length, core held in reset
module imem_boot_loader #(
  parameter int MIPS_SIZE  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reboot,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_waddr,
  output logic [MIPS_SIZE-1:0]  im_wdata,
  output logic                  cpu_rst_n,
  output logic                  boot_done,
  output logic                  boot_err
);

  // One spare bit so a full 2**ADDR_WIDTH load never wraps the counter.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, LOAD, FLUSH, DONE, ERR
  } state_t;

  state_t                 state;
  logic [15:0]            len;
  logic [CNT_W-1:0]       word_cnt;
  logic [1:0]             byte_cnt;
  logic [MIPS_SIZE-9:0]   shift;

  logic                   accept;
  logic [15:0]            len_next;
  logic                   len_bad;
  logic                   last_word;

  assign rx_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == LOAD);
  assign accept    = rx_valid && rx_ready;
  assign len_next  = {len[15:8], rx_data};
  assign len_bad   = (len_next == 16'd0) || (32'(len_next) > (32'd1 << ADDR_WIDTH));
  assign last_word = (32'(word_cnt) == (32'(len) - 32'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      cpu_rst_n <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= LEN_HI;
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= rx_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= rx_data;
            word_cnt <= '0;
            byte_cnt <= '0;
            if (len_bad) begin
              state    <= ERR;
              boot_err <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          im_we <= 1'b0;
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[MIPS_SIZE-17:0], rx_data};
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_waddr <= word_cnt[ADDR_WIDTH-1:0];
              im_wdata <= {shift, rx_data};
              word_cnt <= word_cnt + CNT_ONE;
              if (last_word) state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          im_we     <= 1'b0;
          state     <= DONE;
          cpu_rst_n <= 1'b1;
          boot_done <= 1'b1;
        end
        DONE: begin
          if (reboot) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
            boot_done <= 1'b0;
          end
        end
        ERR: begin
          if (reboot) begin
            state    <= IDLE;
            boot_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: streams hand-built programs and checks
// write pulses, release timing, error handling, reboot and async reset.
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reboot = 1'b0;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        boot_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] wa_q[$], wd_q[$];
  logic [31:0] ea[$], ed[$];

  imem_boot_loader #(.MIPS_SIZE(32), .ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reboot(reboot), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (im_we) begin
      wa_q.push_back(32'(im_waddr));
      wd_q.push_back(im_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic rb);
    int n;
    n = 0;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    while (!rx_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    reboot   = rb;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    reboot   = 1'b0;
    rx_data  = 8'hEE;
  endtask

  // Returns 1 ns after the edge that accepts the final byte.
  task automatic load_stream(input int gap, input int rb_idx);
    for (int i = 0; i < stream.size(); i++)
      send_byte(stream[i], gap, (i == rb_idx));
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); ea.delete(); ed.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'(ea.size()));
    for (int i = 0; i < wa_q.size() && i < ea.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa_q[i], ea[i]);
      check($sformatf("%s_data%0d", tag, i), wd_q[i], ed[i]);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!boot_done && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done"}, 32'(boot_done), 32'd1);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic do_reboot(input string tag);
    @(negedge CLK);
    reboot = 1'b1;
    @(posedge CLK);
    #1;
    reboot = 1'b0;
    check({tag, "_rb_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_rb_done"}, 32'(boot_done), 32'd0);
    check({tag, "_rb_err"}, 32'(boot_err), 32'd0);
  endtask

  task automatic basic_stream();
    stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    ea = {32'h0, 32'h1};
    ed = {32'h20080005, 32'hAC080000};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(im_we), 32'd0);
    check({tag, "_waddr"}, 32'(im_waddr), 32'd0);
    check({tag, "_wdata"}, im_wdata, 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_done"}, 32'(boot_done), 32'd0);
    check({tag, "_err"}, 32'(boot_err), 32'd0);
  endtask

  initial begin
    #2 RST = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Basic load at one byte per cycle, with exact release timing.
    clear_q();
    basic_stream();
    load_stream(0, -1);
    check("basic_last_we", 32'(im_we), 32'd1);
    check("basic_last_addr", 32'(im_waddr), 32'd1);
    check("basic_last_data", im_wdata, 32'hAC080000);
    check("basic_rst_early", 32'(cpu_rst_n), 32'd0);
    @(posedge CLK);
    #1;
    check("basic_we_drop", 32'(im_we), 32'd0);
    check("basic_rst_rise", 32'(cpu_rst_n), 32'd1);
    check("basic_done_rise", 32'(boot_done), 32'd1);
    check("basic_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge CLK);
    check_writes("basic");

    // Reboot from DONE and load a one-word program.
    do_reboot("done");
    clear_q();
    stream = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    ea = {32'h0};
    ed = {32'h11223344};
    load_stream(0, -1);
    wait_done("one");
    check_writes("one");

    // Throttled stream: three idle cycles between bytes.
    do_reboot("thr");
    clear_q();
    basic_stream();
    load_stream(3, -1);
    wait_done("thr");
    check_writes("thr");

    // Reboot coincident with a LOAD byte accept must be ignored.
    do_reboot("ign");
    clear_q();
    basic_stream();
    load_stream(0, 5);
    check("ign_err", 32'(boot_err), 32'd0);
    wait_done("ign");
    check_writes("ign");

    // Zero length goes to ERR with no writes.
    do_reboot("z");
    clear_q();
    stream = {8'h00, 8'h00};
    load_stream(0, -1);
    repeat (3) @(negedge CLK);
    check("zero_err", 32'(boot_err), 32'd1);
    check("zero_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("zero_ready", 32'(rx_ready), 32'd0);
    check("zero_done", 32'(boot_done), 32'd0);
    check_writes("zero");

    // Length 257 exceeds a 256-word memory.
    do_reboot("err");
    clear_q();
    stream = {8'h01, 8'h01};
    load_stream(0, -1);
    repeat (3) @(negedge CLK);
    check("big_err", 32'(boot_err), 32'd1);
    check("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_writes("big");

    // Length 256 fills the memory exactly.
    do_reboot("full_pre");
    clear_q();
    stream = {8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = {8'(i), ~8'(i), 8'hC3, 8'(i + 7)};
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      ea.push_back(32'(i));
      ed.push_back(w);
    end
    load_stream(0, -1);
    check("full_err", 32'(boot_err), 32'd0);
    wait_done("full");
    check_writes("full");

    // Async reset two bytes into the second word.
    do_reboot("ar");
    clear_q();
    stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
    ea = {32'h0};
    ed = {32'h20080005};
    load_stream(0, -1);
    #2 RST = 1'b0;
    #1;
    check_all_zero("arst");
    check_writes("arst_pre");
    @(negedge CLK);
    RST = 1'b1;
    clear_q();
    basic_stream();
    load_stream(0, -1);
    wait_done("arst_post");
    check_writes("arst_post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
